// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: function codes, flag positions, FSM states.
package alu_pkg;

  localparam int ALU_WIDTH = 8;
  localparam int ALU_NREGS = 4;

  localparam logic [3:0] FS_ADD = 4'b0100;
  localparam logic [3:0] FS_SUB = 4'b0101;
  localparam logic [3:0] FS_CMP = 4'b0110;
  localparam logic [3:0] FS_AND = 4'b0111;
  localparam logic [3:0] FS_OR  = 4'b1000;
  localparam logic [3:0] FS_XOR = 4'b1010;
  localparam logic [3:0] FS_LSL = 4'b1011;
  localparam logic [3:0] FS_LSR = 4'b1100;
  localparam logic [3:0] FS_ASL = 4'b1101;
  localparam logic [3:0] FS_ASR = 4'b1110;
  localparam logic [3:0] FS_CSR = 4'b1111;

  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_O = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  // Compare only sets flags; every other code, defined or not, writes rd.
  function automatic logic wb_enable(input logic [3:0] funsel);
    return funsel != FS_CMP;
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Instruction handshake plus the ALU drive/sample bus; slave is the issue stage's view.
interface alu_issue_stage_if #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4
);
  localparam int AW = $clog2(NREGS);

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_funsel;
  logic [AW-1:0]    in_rd;
  logic [AW-1:0]    in_rs1;
  logic [AW-1:0]    in_rs2;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_funsel;
  logic [WIDTH-1:0] alu_out;
  logic [3:0]       alu_flags;

  modport master (
    output in_valid, in_funsel, in_rd, in_rs1, in_rs2,
    input  in_ready,
    input  alu_a, alu_b, alu_funsel,
    output alu_out, alu_flags
  );

  modport slave (
    input  in_valid, in_funsel, in_rd, in_rs1, in_rs2,
    output in_ready,
    output alu_a, alu_b, alu_funsel,
    input  alu_out, alu_flags
  );

endinterface

// File: rtl/operand_regfile.sv
// NREGS x WIDTH operand registers: two operand read ports, one debug read port, one shared write port.
// Writeback wins over the external load; the issue FSM never asserts both in the same cycle.
module operand_regfile #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_we,
  input  logic [AW-1:0]    ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             wb_we,
  input  logic [AW-1:0]    wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b,
  input  logic [AW-1:0]    raddr_dbg,
  output logic [WIDTH-1:0] rdata_dbg
);

  logic [WIDTH-1:0] mem [NREGS];
  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;

  always_comb begin
    we    = wb_we | ld_we;
    waddr = ld_addr;
    wdata = ld_data;
    if (wb_we) begin
      waddr = wb_addr;
      wdata = wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a   = mem[raddr_a];
  assign rdata_b   = mem[raddr_b];
  assign rdata_dbg = mem[raddr_dbg];

endmodule

// File: rtl/alu_issue_stage.sv
// Feeds an external ALU from a small register file: accept, EXEC, WB; done pulses 3 edges after accept.
// in_ready is high only in IDLE, so one instruction is in flight at a time.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int NREGS = ALU_NREGS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  alu_issue_stage_if.slave         bus,
  input  logic                     ld_en,
  input  logic [$clog2(NREGS)-1:0] ld_addr,
  input  logic [WIDTH-1:0]         ld_data,
  output logic                     done,
  output logic [WIDTH-1:0]         result,
  output logic [3:0]               flags,
  output logic [WIDTH-1:0]         rd_data
);

  localparam int AW = $clog2(NREGS);

  state_t           state_q;
  state_t           state_d;
  logic             accept;
  logic             ld_we;
  logic             wb_we;
  logic             in_wb;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [3:0]       funsel_q;
  logic [AW-1:0]    rd_q;
  logic             wb_en_q;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;

  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    bus.in_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: state_d = ST_WB;
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_wb = (state_q == ST_WB);
  // Loads are only honoured while idle; a load on the accept edge lands after the operand read.
  assign ld_we = ld_en && (state_q == ST_IDLE);
  assign wb_we = in_wb && wb_en_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      funsel_q <= 4'b0000;
      rd_q     <= '0;
      wb_en_q  <= 1'b0;
      result   <= '0;
      flags    <= 4'b0000;
      done     <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= in_wb;
      if (accept) begin
        a_q      <= op_a;
        b_q      <= op_b;
        funsel_q <= bus.in_funsel;
        rd_q     <= bus.in_rd;
        wb_en_q  <= wb_enable(bus.in_funsel);
      end
      if (in_wb) begin
        result <= bus.alu_out;
        flags  <= bus.alu_flags;
      end
    end
  end

  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.alu_funsel = funsel_q;

  operand_regfile #(
    .WIDTH (WIDTH),
    .NREGS (NREGS),
    .AW    (AW)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .ld_we     (ld_we),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .wb_we     (wb_we),
    .wb_addr   (rd_q),
    .wb_data   (bus.alu_out),
    .raddr_a   (bus.in_rs1),
    .rdata_a   (op_a),
    .raddr_b   (bus.in_rs2),
    .rdata_b   (op_b),
    .raddr_dbg (ld_addr),
    .rdata_dbg (rd_data)
  );

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Upstream feeder for the 8-bit ALU: holds a small operand register file and accepts one ALU instruction at a time on a valid/ready handshake.
- Drives the ALU's A, B and FunSel inputs, then writes OutALU back to the destination register and latches the Flags.
- Sits between the instruction source (control unit or testbench) and the ALU.
- The ALU itself stays external; this block only drives and samples it.

Parameters:
- WIDTH, 8, data width; must match the ALU.
- NREGS, 4, number of operand registers. Address width is log2(NREGS) = 2.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction offered
- in_ready  out  1  instruction can be accepted
- in_funsel  in  4  ALU function code, passed to the ALU unchanged
- in_rd  in  2  destination register
- in_rs1  in  2  source register driven on ALU A
- in_rs2  in  2  source register driven on ALU B
- ld_en  in  1  external register load strobe
- ld_addr  in  2  external load address
- ld_data  in  WIDTH  external load data
- alu_a  out  WIDTH  to ALU A
- alu_b  out  WIDTH  to ALU B
- alu_funsel  out  4  to ALU FunSel
- alu_out  in  WIDTH  from ALU OutALU
- alu_flags  in  4  from ALU Flags; bit3..0 = Z, C, N, O
- done  out  1  one-cycle pulse, instruction retired
- result  out  WIDTH  last ALU result
- flags  out  4  last captured flags
- rd_data  out  WIDTH  combinational read of regfile[ld_addr], for debug and bench checking

Behaviour:
- Reset, async on rst_n low:
  - state=IDLE
  - all registers = 0
  - alu_a = alu_b = 0; alu_funsel = 4'b0000
  - result = 0; flags = 0; done = 0; in_ready = 1 once rst_n is released
- State machine:
  - IDLE: in_ready = 1. On in_valid && in_ready at an edge:
    - alu_a <= reg[in_rs1]; alu_b <= reg[in_rs2]; alu_funsel <= in_funsel
    - latch in_rd and the writeback-enable (wb_en)
    - go to EXEC
  - EXEC, 1 cycle: ALU inputs are stable. The ALU's own clocked flag register updates at the end of this cycle. Go to WB.
  - WB, 1 cycle: alu_out and alu_flags are sampled at the end of the cycle.
    - result <= alu_out; flags <= alu_flags
    - if wb_en: reg[rd] <= alu_out
    - done <= 1 for the next cycle; go to IDLE
- Timing:
  - Latency: accept edge T, done high in cycle T+3.
  - Throughput: one instruction per 3 cycles. A new instruction may be accepted in the same cycle done is high.
  - alu_a, alu_b and alu_funsel are registered and held constant from EXEC through WB. They keep their last values in IDLE.
- Writeback enable:
  - wb_en = 0 for CMP (4'b0110): flags and result update, the register file does not.
  - wb_en = 1 for every other code, including codes the ALU leaves undefined.
- Handshake:
  - in_ready = (state==IDLE).
  - Instruction fields are sampled only at the accept edge; later changes are ignored.
- External load:
  - ld_en is honoured only in IDLE. In EXEC and WB it is silently dropped.
  - If ld_en and a handshake accept occur on the same IDLE edge:
    - operand reads see the pre-load register values
    - the load still commits
- Reset mid-operation (EXEC or WB): the instruction is aborted with no writeback and no done pulse. All state returns to reset values.

Decomposition:
- Shared package alu_pkg:
  - FunSel localparams: ADD 0100, SUB 0101, CMP 0110, AND 0111, OR 1000, XOR 1010, LSL 1011, LSR 1100, ASL 1101, ASR 1110, CSR 1111
  - flag bit indices: Z=3, C=2, N=1, O=0
  - state encoding
- One natural sub-module, operand_regfile:
  - NREGS x WIDTH
  - two combinational read ports and one debug read port
  - one write port muxed between the external load and writeback
  - async active-low reset to 0

Test Plan:
1. Load R0=0x33, R1=0x0F; issue ADD rd=R2 rs1=R0 rs2=R1 -> in EXEC: alu_a=0x33, alu_b=0x0F, alu_funsel=0100; done at T+3; R2=0x42; flags=0000.
2. Load R0=0x40, R1=0x38; issue CMP rd=R0 -> done pulses, flags reflect 0x40-0x38 (Z=0, N=0), R0 still 0x40.
3. Back-to-back handshake: in_valid held high for AND then OR with R0=0xAA, R1=0xF0 -> accepts 3 cycles apart; in_ready low in EXEC and WB; AND result 0xA0, then OR 0xFA written.
4. ld_en asserted to R3=0x55 during EXEC -> dropped, R3 unchanged. ld_en on the same IDLE edge as an accept with rs1=R3 -> ALU sees the old R3, the load commits.
5. Assert rst_n low during WB of ADD into R2 -> no done, R2=0, result=0, flags=0, state IDLE, in_ready=1 after release.
6. Change in_rs1 and in_funsel during EXEC -> alu_a and alu_funsel unchanged until the next accept.
